// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared definitions for the multiplexed 7-segment display scan path.
//
//   Contents:
//     BCD_W          width of one BCD digit code
//     MAX_DIGITS     widest display this controller family supports
//     ANODE_ALL_OFF  active-low anode pattern with every digit dark
//     scan_state_e   scan FSM encoding (S_BLANK = 0, S_SHOW = 1)
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    // Common-anode enables are active-low, so "all off" is all ones. Slice
    // the low DIGITS bits for a narrower display.
    localparam logic [MAX_DIGITS-1:0] ANODE_ALL_OFF = '1;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
//   Free-running modulo-PRESCALE counter that produces the scan tick.
//
//   Ports:
//     i_clk    system clock
//     i_rst_n  asynchronous active-low reset
//     i_clr    synchronous clear (held while scanning is disabled)
//     o_tick   high for the one cycle in which the count equals PRESCALE-1
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                CNT_W   = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_clr || (count_q == CNT_MAX)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    // A clear cycle never counts as a tick, so re-enabling always waits a
    // full PRESCALE period before the first one.
    assign o_tick = (count_q == CNT_MAX) && !i_clr;

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexed scan controller for a common-anode 7-segment display.
//   Each digit slot is BLANK_TICKS ticks with every anode off, followed by
//   SHOW_TICKS ticks with that digit's anode on. The BCD code of the digit
//   is presented to the shared decoder from the start of its blank interval.
//   Digit values are double-buffered: i_load fills a shadow register, and
//   the shadow is copied to the active register at the frame wrap (or at
//   once while scanning is disabled).
//
//   Build option:
//     LEAD_ZERO_BLANK_EN  when defined, a digit above digit 0 whose value and
//                         all higher digit values are zero stays dark during
//                         its show interval (slot timing and o_bcd unchanged).
//
//   Ports:
//     i_clk         system clock
//     i_rst_n       asynchronous active-low reset
//     i_en          scan enable; low parks the scan at S_BLANK, digit 0
//     i_load        one-cycle strobe capturing i_digits into the shadow
//     i_digits      packed BCD digits, digit 0 in bits [3:0] (least significant)
//     o_bcd         BCD code of the current digit, to the shared decoder
//     o_anode_n     active-low one-hot digit enables
//     o_pending     shadow holds data not yet committed to the display
//     o_frame_done  one-cycle pulse when the digit index wraps to 0
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 1000,
    parameter int SHOW_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_load,
    input  logic [BCD_W*DIGITS-1:0]   i_digits,
    output logic [BCD_W-1:0]          o_bcd,
    output logic [DIGITS-1:0]         o_anode_n,
    output logic                      o_pending,
    output logic                      o_frame_done
);

    localparam int MAX_TICKS = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int TCNT_W    = $clog2(MAX_TICKS + 1);
    localparam int IDX_W     = $clog2(DIGITS);

    localparam logic [TCNT_W-1:0] BLANK_LAST = TCNT_W'(BLANK_TICKS - 1);
    localparam logic [TCNT_W-1:0] SHOW_LAST  = TCNT_W'(SHOW_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ANODE_OFF  = ANODE_ALL_OFF[DIGITS-1:0];

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic tick;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!i_en),
        .o_tick  (tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_e                 state_q, state_d;
    logic [TCNT_W-1:0]           tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [BCD_W*DIGITS-1:0]     shadow_q, shadow_d;
    logic [BCD_W*DIGITS-1:0]     active_q, active_d;
    logic                        pending_q, pending_d;
    logic                        wrap;
    logic                        commit;

    logic [BCD_W-1:0]            bcd_d;
    logic [DIGITS-1:0]           anode_d;
    logic                        lit;

    // ------------------------------------------------------------------
    // Next-state: scan FSM, digit index, double buffer
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        idx_d      = idx_q;
        wrap       = 1'b0;

        if (!i_en) begin
            state_d    = S_BLANK;
            tick_cnt_d = '0;
            idx_d      = '0;
        end else if (tick) begin
            case (state_q)
                S_BLANK: begin
                    if (tick_cnt_q == BLANK_LAST) begin
                        state_d    = S_SHOW;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (tick_cnt_q == SHOW_LAST) begin
                        state_d    = S_BLANK;
                        tick_cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // The commit uses the pre-edge shadow, so a load landing on the
        // commit cycle goes into the shadow and stays pending for one more
        // frame.
        commit    = pending_q && (wrap || !i_en);
        active_d  = commit ? shadow_q : active_q;
        shadow_d  = i_load ? i_digits : shadow_q;
        pending_d = i_load || (pending_q && !commit);
    end

    // ------------------------------------------------------------------
    // Registered outputs, computed from next-state values so they change
    // in the same cycle as the state they describe.
    // ------------------------------------------------------------------
`ifdef LEAD_ZERO_BLANK_EN
    logic upper_nonzero;
`endif

    always_comb begin
        bcd_d   = active_d[BCD_W*idx_d +: BCD_W];
        lit     = (state_d == S_SHOW);
        anode_d = ANODE_OFF;

`ifdef LEAD_ZERO_BLANK_EN
        upper_nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx_d)) && (active_d[BCD_W*i +: BCD_W] != '0)) begin
                upper_nonzero = 1'b1;
            end
        end
        // Digit 0 always lights so a value of zero still shows "0".
        if ((idx_d != '0) && !upper_nonzero) begin
            lit = 1'b0;
        end
`endif

        if (lit) begin
            anode_d[idx_d] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: the digit buffers are ordinary registers, not RAM, so they are
    // reset with everything else and the display powers up showing zeros.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_BLANK;
            tick_cnt_q   <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            o_bcd        <= '0;
            o_anode_n    <= ANODE_OFF;
            o_frame_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            o_bcd        <= bcd_d;
            o_anode_n    <= anode_d;
            o_frame_done <= wrap;
        end
    end

    assign o_pending = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Self-checking bench for display_scan_ctrl (DIGITS=4, PRESCALE=4,
//   SHOW_TICKS=2, BLANK_TICKS=1: slot = 12 cycles, frame = 48 cycles).
//   The reference model tracks the number of enabled clock edges since the
//   scan last restarted and derives slot, phase and digit from it with
//   integer arithmetic; the double buffer is modelled as plain variables.
//   Honours LEAD_ZERO_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int DIGITS      = 4;
    localparam int PRESCALE    = 4;
    localparam int SHOW_TICKS  = 2;
    localparam int BLANK_TICKS = 1;
    localparam int SLOT_TICKS  = BLANK_TICKS + SHOW_TICKS;
    localparam int FRAME_CYC   = SLOT_TICKS * PRESCALE * DIGITS;
    localparam int DW          = 4 * DIGITS;

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [3:0] AN_IDX1_ZERO = 4'hF;
    localparam logic [3:0] AN_IDX3_ZERO = 4'hF;
    localparam logic [3:0] LZ_MASK      = 4'b0011;
`else
    localparam logic [3:0] AN_IDX1_ZERO = 4'hD;
    localparam logic [3:0] AN_IDX3_ZERO = 4'h7;
    localparam logic [3:0] LZ_MASK      = 4'b1111;
`endif

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              load;
    logic [DW-1:0]     digits;
    logic [3:0]        bcd;
    logic [DIGITS-1:0] anode_n;
    logic              pending;
    logic              frame_done;

    display_scan_ctrl #(
        .DIGITS      (DIGITS),
        .PRESCALE    (PRESCALE),
        .SHOW_TICKS  (SHOW_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_load       (load),
        .i_digits     (digits),
        .o_bcd        (bcd),
        .o_anode_n    (anode_n),
        .o_pending    (pending),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int            m_c;        // enabled edges since reset / last disable
    logic [DW-1:0] m_shadow;
    logic [DW-1:0] m_active;
    logic          m_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c       = 0;
        m_shadow  = '0;
        m_active  = '0;
        m_pending = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic ld, input logic [DW-1:0] d);
        logic wrap;
        logic commit;
        wrap   = e && (((m_c + 1) % FRAME_CYC) == 0);
        commit = m_pending && (wrap || !e);
        m_c    = e ? m_c + 1 : 0;
        if (commit) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_shadow  = d;
            m_pending = 1'b1;
        end
    endtask

    task automatic model_expect(output logic [3:0] an, output logic [3:0] b, output logic done);
        int k;
        int phase;
        int idx;
        k     = m_c / PRESCALE;
        phase = k % SLOT_TICKS;
        idx   = (k / SLOT_TICKS) % DIGITS;
        b     = m_active[4*idx +: 4];
        an    = '1;
        if (phase >= BLANK_TICKS) an[idx] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        if ((idx > 0) && ((m_active >> (4*idx)) == '0)) an = '1;
`endif
        done = (m_c > 0) && ((m_c % FRAME_CYC) == 0);
    endtask

    task automatic compare_model();
        logic [3:0] e_an;
        logic [3:0] e_bcd;
        logic       e_done;
        model_expect(e_an, e_bcd, e_done);
        check("anode",      32'(anode_n),    32'(e_an));
        check("bcd",        32'(bcd),        32'(e_bcd));
        check("pending",    32'(pending),    32'(m_pending));
        check("frame_done", 32'(frame_done), 32'(e_done));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic e, input logic ld, input logic [DW-1:0] d);
        en     = e;
        load   = ld;
        digits = d;
        @(posedge clk);
        model_edge(e, ld, d);
        #1;
        compare_model();
    endtask

    // Run enabled, idle cycles until the model sits at a given frame offset.
    task automatic run_to(input int target);
        for (int i = 0; (i < FRAME_CYC) && ((m_c % FRAME_CYC) != target); i++) begin
            step(1'b1, 1'b0, '0);
        end
    endtask

    typedef struct {
        logic          en;
        logic          load;
        logic [DW-1:0] digits;
        int            cycles;
        logic [3:0]    anode;
        logic [3:0]    bcd;
        logic          pending;
        logic          done;
    } vec_t;

    initial begin : main
        vec_t       tbl [16];
        int         lat;
        bit         found;
        logic [3:0] lit_mask;
        logic [DW-1:0] rd;

        // First frame from reset with 1234 loaded, then the second frame.
        tbl[0]  = '{1'b1, 1'b1, 16'h1234,  1, 4'hF,         4'h0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000,  2, 4'hF,         4'h0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000,  1, 4'hE,         4'h0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000,  7, 4'hE,         4'h0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000,  1, 4'hF,         4'h0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000,  4, AN_IDX1_ZERO, 4'h0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 31, AN_IDX3_ZERO, 4'h0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000,  1, 4'hF,         4'h4, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000,  1, 4'hF,         4'h4, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000,  3, 4'hE,         4'h4, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h0000,  8, 4'hF,         4'h3, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 16'h0000,  4, 4'hD,         4'h3, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 16'h0000,  8, 4'hF,         4'h2, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 16'h0000,  4, 4'hB,         4'h2, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 16'h0000, 12, 4'h7,         4'h1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 16'h0000,  8, 4'hF,         4'h4, 1'b0, 1'b1};

        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        digits = '0;
        model_reset();

        #12;
        check("rst_anode",   32'(anode_n),    32'hF);
        check("rst_bcd",     32'(bcd),        32'h0);
        check("rst_pending", 32'(pending),    32'h0);
        check("rst_done",    32'(frame_done), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven first two frames
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < tbl[r].cycles; j++) begin
                step(tbl[r].en, tbl[r].load, tbl[r].digits);
            end
            check($sformatf("tbl%0d_anode", r),   32'(anode_n),    32'(tbl[r].anode));
            check($sformatf("tbl%0d_bcd", r),     32'(bcd),        32'(tbl[r].bcd));
            check($sformatf("tbl%0d_pending", r), 32'(pending),    32'(tbl[r].pending));
            check($sformatf("tbl%0d_done", r),    32'(frame_done), 32'(tbl[r].done));
        end

        // Mid-frame load: display keeps 1234 until the wrap commits 5678.
        repeat (20) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 16'h5678);
        check("midload_pending", 32'(pending), 32'h1);
        check("midload_bcd",     32'(bcd),     32'h3);
        check("midload_anode",   32'(anode_n), 32'hD);
        run_to(FRAME_CYC - 1);
        step(1'b1, 1'b0, '0);
        check("commit_done",    32'(frame_done), 32'h1);
        check("commit_bcd",     32'(bcd),        32'h8);
        check("commit_pending", 32'(pending),    32'h0);

        // Load on the exact commit cycle: old shadow commits, new stays pending.
        step(1'b1, 1'b1, 16'h1111);
        run_to(FRAME_CYC - 1);
        step(1'b1, 1'b1, 16'h9999);
        check("ldcommit_done",    32'(frame_done), 32'h1);
        check("ldcommit_bcd",     32'(bcd),        32'h1);
        check("ldcommit_pending", 32'(pending),    32'h1);
        run_to(FRAME_CYC - 1);
        step(1'b1, 1'b0, '0);
        check("ldcommit2_bcd",     32'(bcd),     32'h9);
        check("ldcommit2_pending", 32'(pending), 32'h0);

        // Disable mid-SHOW on digit 2, with a pending load committing at once.
        run_to(30);
        check("dis_pre_anode", 32'(anode_n), 32'hB);
        step(1'b1, 1'b1, 16'h4321);
        step(1'b0, 1'b0, '0);
        check("dis_anode",   32'(anode_n),    32'hF);
        check("dis_bcd",     32'(bcd),        32'h1);
        check("dis_pending", 32'(pending),    32'h0);
        check("dis_done",    32'(frame_done), 32'h0);
        repeat (9) step(1'b0, 1'b0, '0);
        lat   = 0;
        found = 1'b0;
        for (int i = 0; (i < 20) && !found; i++) begin
            step(1'b1, 1'b0, '0);
            lat++;
            if (anode_n != 4'hF) found = 1'b1;
        end
        check("reen_latency", 32'(lat),     32'(BLANK_TICKS * PRESCALE));
        check("reen_anode",   32'(anode_n), 32'hE);

        // Asynchronous reset mid-SHOW with data pending.
        run_to(30);
        step(1'b1, 1'b1, 16'h5555);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_anode",   32'(anode_n), 32'hF);
        check("arst_bcd",     32'(bcd),     32'h0);
        check("arst_pending", 32'(pending), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Leading-zero behaviour on 0070 over one full frame.
        step(1'b1, 1'b1, 16'h0070);
        run_to(FRAME_CYC - 1);
        step(1'b1, 1'b0, '0);
        check("lz_commit_done", 32'(frame_done), 32'h1);
        lit_mask = '0;
        repeat (FRAME_CYC) begin
            step(1'b1, 1'b0, '0);
            lit_mask = lit_mask | ~anode_n;
        end
        check("lz_lit_mask", 32'(lit_mask), 32'(LZ_MASK));

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            for (int n = 0; n < DIGITS; n++) begin
                rd[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 29) == 0), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
